// File: rtl/alsu_pkg.sv
// Shared types and constants for the ALSU sequencer.
// Holds the FSM state encoding, the op-class codes and the default datapath width.
package alsu_pkg;

    localparam int W_DEF = 4;

    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] SHR   = 2'b10;
    localparam logic [1:0] SHL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alsu_seq.sv
// Sequencer that drives an external ALSU and accumulates its result.
// Shift ops repeat (count+1) times; arithmetic/logic ops take a single pass.
module alsu_seq
    import alsu_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_load,
    input  logic [3:0]   req_op,
    input  logic         req_cin,
    input  logic [W-1:0] req_operand,
    input  logic [1:0]   req_count,
    output logic         alsu_s0,
    output logic         alsu_s1,
    output logic         alsu_s2,
    output logic         alsu_s3,
    output logic         alsu_cin,
    output logic [W-1:0] alsu_a,
    output logic [W-1:0] alsu_b,
    input  logic [W-1:0] alsu_f,
    input  logic         alsu_carry,
    output logic [W-1:0] acc,
    output logic         e_flag,
    output logic         busy,
    output logic         done
);

    state_t       state;
    state_t       state_nx;
    logic [3:0]   op_q;
    logic         cin_q;
    logic [W-1:0] opnd_q;
    logic         ld_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cls;
    logic         shift;
    logic         accept;

    assign cls    = op_q[3:2];
    assign shift  = cls[1];
    assign accept = req_valid && req_ready;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    assign alsu_s0  = op_q[0];
    assign alsu_s1  = op_q[1];
    assign alsu_s2  = op_q[2];
    assign alsu_s3  = op_q[3];
    assign alsu_cin = cin_q;
    assign alsu_a   = shift ? acc : opnd_q;
    assign alsu_b   = shift ? opnd_q : acc;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = req_load ? DONE : EXEC;
            EXEC: if (!shift || cnt_q == 2'd0) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            cin_q  <= 1'b0;
            opnd_q <= '0;
            ld_q   <= 1'b0;
            cnt_q  <= '0;
            acc    <= '0;
            e_flag <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q   <= req_op;
                cin_q  <= req_cin;
                opnd_q <= req_operand;
                ld_q   <= req_load;
                cnt_q  <= req_count;
                if (req_load) acc <= req_operand;
            end
            // e_flag captures the pre-update acc bit shifted out
            if (state == EXEC && !ld_q) begin
                acc <= alsu_f;
                if (shift && cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
                unique case (cls)
                    ARITH: e_flag <= alsu_carry;
                    LOGIC: e_flag <= e_flag;
                    SHR:   e_flag <= acc[0];
                    SHL:   e_flag <= acc[W-1];
                    default: e_flag <= e_flag;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alsu_seq.sv
// Bench for alsu_seq: wraps it with a behavioural ALSU and checks
// directed and random requests against an arithmetic reference model.
module tb_alsu_seq;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_load;
    logic [3:0]   req_op;
    logic         req_cin;
    logic [W-1:0] req_operand;
    logic [1:0]   req_count;
    logic         alsu_s0, alsu_s1, alsu_s2, alsu_s3, alsu_cin;
    logic [W-1:0] alsu_a, alsu_b, alsu_f;
    logic         alsu_carry;
    logic [W-1:0] acc;
    logic         e_flag, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int m_acc   = 0;
    int m_e     = 0;

    always #5 clk = ~clk;

    alsu_seq #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_op(req_op), .req_cin(req_cin),
        .req_operand(req_operand), .req_count(req_count),
        .alsu_s0(alsu_s0), .alsu_s1(alsu_s1),
        .alsu_s2(alsu_s2), .alsu_s3(alsu_s3),
        .alsu_cin(alsu_cin), .alsu_a(alsu_a), .alsu_b(alsu_b),
        .alsu_f(alsu_f), .alsu_carry(alsu_carry),
        .acc(acc), .e_flag(e_flag), .busy(busy), .done(done)
    );

    // External ALSU: arith/logic/shift-right/shift-left by {s3,s2}
    always_comb begin
        logic [W:0] sum;
        logic [3:0] sel;
        sel = {alsu_s3, alsu_s2, alsu_s1, alsu_s0};
        sum = '0;
        case (sel[3:2])
            2'b00: case (sel[1:0])
                2'b00: sum = {1'b0, alsu_a} + {1'b0, alsu_b} + alsu_cin;
                2'b01: sum = {1'b0, alsu_a} + {1'b0, ~alsu_b} + alsu_cin;
                2'b10: sum = {1'b0, alsu_a} + alsu_cin;
                default: sum = {1'b0, alsu_a} + {1'b0, {W{1'b1}}} + alsu_cin;
            endcase
            2'b01: case (sel[1:0])
                2'b00: sum = {1'b0, alsu_a & alsu_b};
                2'b01: sum = {1'b0, alsu_a | alsu_b};
                2'b10: sum = {1'b0, alsu_a ^ alsu_b};
                default: sum = {1'b0, ~alsu_a};
            endcase
            2'b10: sum = {alsu_a[0], 1'b0, alsu_a[W-1:1]};
            default: sum = {alsu_a, 1'b0};
        endcase
        alsu_f     = sum[W-1:0];
        alsu_carry = sum[W];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic ld, input logic [3:0] op,
                       input logic c, input logic [W-1:0] opd,
                       input logic [1:0] cnt, input logic poke,
                       input string tag);
        int n, t, a, b, s, lat, acc0;
        bit seen;
        acc0 = m_acc;
        n = 0;
        a = int'(opd);
        b = m_acc;
        if (ld) begin
            m_acc = a;
        end else begin
            case (op[3:2])
                2'b00: begin
                    n = 1;
                    case (op[1:0])
                        2'b00: s = a + b + c;
                        2'b01: s = a + (MASK - b) + c;
                        2'b10: s = a + c;
                        default: s = a + MASK + c;
                    endcase
                    m_acc = s & MASK;
                    m_e = (s >> W) & 1;
                end
                2'b01: begin
                    n = 1;
                    case (op[1:0])
                        2'b00: m_acc = a & b;
                        2'b01: m_acc = a | b;
                        2'b10: m_acc = a ^ b;
                        default: m_acc = ~a & MASK;
                    endcase
                end
                2'b10: begin
                    t = int'(cnt) + 1;
                    n = t;
                    m_e = (acc0 >> (t - 1)) & 1;
                    m_acc = acc0 >> t;
                end
                default: begin
                    t = int'(cnt) + 1;
                    n = t;
                    m_e = (acc0 >> (W - t)) & 1;
                    m_acc = (acc0 << t) & MASK;
                end
            endcase
        end
        @(negedge clk);
        chk({tag, " ready_idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_load = ld;
        req_op = op;
        req_cin = c;
        req_operand = opd;
        req_count = cnt;
        @(posedge clk);
        #1;
        if (poke) begin
            req_load = 1'b1;
            req_operand = ~opd;
        end else begin
            req_valid = 1'b0;
        end
        seen = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                lat = k;
            end else begin
                chk({tag, " ready_busy"}, req_ready, 0);
                chk({tag, " busy"}, busy, 1);
                if (!ld && op[3] && k >= 2)
                    chk({tag, " acc_step"}, acc, op[2] ?
                        ((acc0 << (k - 1)) & MASK) : (acc0 >> (k - 1)));
            end
        end
        req_valid = 1'b0;
        chk({tag, " latency"}, lat, n + 1);
        chk({tag, " acc"}, acc, m_acc);
        chk({tag, " e_flag"}, e_flag, m_e);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " ready_after"}, req_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b1;
        req_load = 1'b1;
        req_op = 4'hF;
        req_cin = 1'b1;
        req_operand = 4'hF;
        req_count = 2'd3;
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst acc", acc, 0);
        chk("rst e", e_flag, 0);
        chk("rst ready", req_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst sel", {alsu_s3, alsu_s2, alsu_s1, alsu_s0, alsu_cin}, 0);
        chk("rst ab", {alsu_a, alsu_b}, 0);

        run(1, 4'h0, 0, 4'b0101, 0, 0, "add_ld");
        run(0, 4'h0, 0, 4'b1010, 0, 0, "add");
        run(1, 4'h0, 0, 4'b1101, 0, 0, "carry_ld");
        run(0, 4'h0, 0, 4'b0011, 0, 0, "carry");
        run(1, 4'h0, 0, 4'b0101, 0, 0, "and_ld");
        run(0, 4'h4, 0, 4'b1010, 0, 0, "and");
        run(1, 4'h0, 0, 4'b0101, 0, 0, "shr_ld");
        run(0, 4'h8, 0, 4'b0000, 1, 0, "shr");
        run(1, 4'h0, 0, 4'b0101, 0, 0, "shl_ld");
        run(0, 4'hC, 0, 4'b0000, 0, 1, "shl_poke");

        run(1, 4'h0, 0, 4'b1111, 0, 0, "rst_ld");
        @(negedge clk);
        req_valid = 1'b1;
        req_load = 1'b0;
        req_op = 4'hC;
        req_count = 2'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst step", acc, 4'b1110);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst acc", acc, 0);
        chk("midrst e", e_flag, 0);
        chk("midrst ready", req_ready, 1);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        m_acc = 0;
        m_e = 0;
        @(negedge clk);
        chk("midrst nodone", done, 0);

        for (int i = 0; i < 40; i++) begin
            run($urandom_range(0, 3) == 0, 4'($urandom),
                1'($urandom), W'($urandom), 2'($urandom), 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
